// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control unit: sequences PC, IR, register file, ALU and
// data memory one phase per clock, and counts retired instructions for debug.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'h00,
  parameter logic [5:0]  OP_ADDI  = 6'h08,
  parameter logic [5:0]  OP_ORI   = 6'h0D,
  parameter logic [5:0]  OP_LW    = 6'h23,
  parameter logic [5:0]  OP_SW    = 6'h2B,
  parameter logic [5:0]  OP_BEQ   = 6'h04,
  parameter logic [5:0]  OP_J     = 6'h02
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcWire,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic       retire;
  logic       supported;
  logic [2:0] rtype_alu_op;
  logic       rtype_ok;

  assign state = cur_state;

  // R-type function decode; unknown functs are treated as unsupported
  always_comb begin
    rtype_alu_op = ALU_ADD;
    rtype_ok     = 1'b1;
    case (funct)
      FN_ADD:  rtype_alu_op = ALU_ADD;
      FN_SUB:  rtype_alu_op = ALU_SUB;
      FN_AND:  rtype_alu_op = ALU_AND;
      FN_OR:   rtype_alu_op = ALU_OR;
      FN_SLT:  rtype_alu_op = ALU_SLT;
      default: rtype_ok     = 1'b0;
    endcase
  end

  always_comb begin
    supported = 1'b0;
    case (opcode)
      OP_RTYPE: supported = rtype_ok;
      OP_ADDI,
      OP_ORI,
      OP_LW,
      OP_SW,
      OP_BEQ,
      OP_J:     supported = 1'b1;
      default:  supported = 1'b0;
    endcase
  end

  // Next-state and datapath control decode
  always_comb begin
    nxt_state  = S_IF;
    retire     = 1'b0;
    pcWire     = 1'b0;
    pc_src     = PC_SEQ;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;

    case (cur_state)
      S_IF: begin
        ir_write  = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pcWire    = 1'b1;
        nxt_state = S_ID;
      end

      // Branch target is precomputed here while the opcode settles
      S_ID: begin
        alu_src_b = SRCB_SEXT;
        if (opcode == OP_J) begin
          pcWire    = 1'b1;
          pc_src    = PC_JUMP;
          retire    = 1'b1;
          nxt_state = S_IF;
        end else if (!supported) begin
          retire    = 1'b1;
          nxt_state = S_IF;
        end else begin
          nxt_state = S_EXE;
        end
      end

      S_EXE: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            alu_src_b = SRCB_RT;
            alu_op    = rtype_alu_op;
            nxt_state = S_WB;
          end
          OP_ADDI: begin
            alu_src_b = SRCB_SEXT;
            nxt_state = S_WB;
          end
          OP_LW,
          OP_SW: begin
            alu_src_b = SRCB_SEXT;
            nxt_state = S_MEM;
          end
          OP_ORI: begin
            alu_src_b = SRCB_ZEXT;
            alu_op    = ALU_OR;
            nxt_state = S_WB;
          end
          OP_BEQ: begin
            alu_src_b = SRCB_RT;
            alu_op    = ALU_SUB;
            pc_src    = PC_BRANCH;
            pcWire    = zero;
            retire    = 1'b1;
            nxt_state = S_IF;
          end
          default: nxt_state = S_IF;
        endcase
      end

      S_MEM: begin
        case (opcode)
          OP_LW: begin
            mem_read  = 1'b1;
            nxt_state = S_WB;
          end
          OP_SW: begin
            mem_write = 1'b1;
            retire    = 1'b1;
            nxt_state = S_IF;
          end
          default: nxt_state = S_IF;
        endcase
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        mem_to_reg = (opcode == OP_LW);
        retire     = 1'b1;
        nxt_state  = S_IF;
      end

      // Illegal encodings recover to fetch with everything idle
      default: nxt_state = S_IF;
    endcase

    // Reset holds the datapath quiet so the PC loads its reset value untouched
    if (reset) begin
      retire     = 1'b0;
      pcWire     = 1'b0;
      pc_src     = PC_SEQ;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALU_ADD;
    end
  end

  // State register and wrapping retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_IF;
      instr_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

endmodule
